// File: rtl/colourise_ctrl_if.sv
// colourise_ctrl_if -- configuration request channel for colourise_ctrl.
//
// Signals:
//   cfg_valid  requester marks a configuration request
//   cfg_ready  controller can accept a request this cycle
//   cfg_mode   requested colourise mode (3 bits)
//   cfg_auto   1 requests auto-cycling through modes 0..MODE_MAX
//   cfg_dwell  frames per auto-cycle step (0 behaves as 1)
//
// Modports: master (requester side), slave (controller side).
interface colourise_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_mode;
  logic       cfg_auto;
  logic [7:0] cfg_dwell;

  modport master (
    output cfg_valid,
    output cfg_mode,
    output cfg_auto,
    output cfg_dwell,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_mode,
    input  cfg_auto,
    input  cfg_dwell,
    output cfg_ready
  );
endinterface

// File: rtl/colourise_ctrl.sv
// colourise_ctrl -- frame-synchronous mode controller for the colourise datapath.
//
// Configuration requests are accepted on the cfg channel and applied only on a
// frame boundary (rising into the active vsync level). In auto mode the output
// mode steps 0..MODE_MAX every max(dwell,1) frames.
//
// Ports:
//   PixelClk     pixel clock, all state on its rising edge
//   aRst         asynchronous active-high reset
//   vid_pVSync   video vertical sync (active level = VSYNC_POL)
//   cfg          configuration request channel (colourise_ctrl_if.slave)
//   mode_out     mode for the colourise datapath
//   frame_start  one-cycle pulse per frame boundary
//   pending      an accepted request is waiting for a frame boundary
//   frame_cnt    frame counter (constant 0 unless enabled)
//
// Optional feature: define COLOURISE_CTRL_FRAME_CNT_EN to build the 16-bit
// wrapping frame counter.
module colourise_ctrl #(
  parameter bit         VSYNC_POL = 1'b1,
  parameter logic [2:0] MODE_MAX  = 3'd1
) (
  input  logic                    PixelClk,
  input  logic                    aRst,
  input  logic                    vid_pVSync,
  colourise_ctrl_if.slave         cfg,
  output logic [2:0]              mode_out,
  output logic                    frame_start,
  output logic                    pending,
  output logic [15:0]             frame_cnt
);

  typedef enum logic [1:0] {StIdle, StPending, StAuto} state_e;

  state_e     state_q, state_d;
  logic       vsync_q;
  logic       fb;
  logic       accept;
  logic       frame_start_q;
  logic [2:0] mode_q, mode_d;
  logic [2:0] lat_mode_q, lat_mode_d;
  logic       lat_auto_q, lat_auto_d;
  logic [7:0] lat_dwell_q, lat_dwell_d;
  logic [7:0] dwell_cnt_q, dwell_cnt_d;
  logic [7:0] dwell_eff;
  logic [8:0] dwell_inc;
  logic [2:0] mode_clamped;

  assign fb        = (vid_pVSync == VSYNC_POL) && (vsync_q != VSYNC_POL);
  assign cfg.cfg_ready = (state_q != StPending);
  assign accept    = cfg.cfg_valid && cfg.cfg_ready;
  assign pending   = (state_q == StPending);
  assign mode_out  = mode_q;
  assign frame_start = frame_start_q;

  assign dwell_eff    = (lat_dwell_q == 8'd0) ? 8'd1 : lat_dwell_q;
  assign dwell_inc    = {1'b0, dwell_cnt_q} + 9'd1;
  assign mode_clamped = (lat_mode_q > MODE_MAX) ? MODE_MAX : lat_mode_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lat_mode_d  = lat_mode_q;
    lat_auto_d  = lat_auto_q;
    lat_dwell_d = lat_dwell_q;
    dwell_cnt_d = dwell_cnt_q;

    // A request accepted on a boundary cycle is deliberately not applied on
    // that boundary; it waits in StPending for the next one.
    if (accept) begin
      lat_mode_d  = cfg.cfg_mode;
      lat_auto_d  = cfg.cfg_auto;
      lat_dwell_d = cfg.cfg_dwell;
      state_d     = StPending;
    end

    unique case (state_q)
      StIdle: begin
        // mode holds; boundaries only pulse frame_start
      end
      StPending: begin
        if (fb) begin
          // Manual mode passes out-of-range modes through; auto starts clamped.
          mode_d      = lat_auto_q ? mode_clamped : lat_mode_q;
          dwell_cnt_d = 8'd0;
          state_d     = lat_auto_q ? StAuto : StIdle;
        end
      end
      StAuto: begin
        // An accepted request freezes cycling until it is applied.
        if (fb && !accept) begin
          if (dwell_inc >= {1'b0, dwell_eff}) begin
            dwell_cnt_d = 8'd0;
            mode_d      = (mode_q >= MODE_MAX) ? 3'd0 : mode_q + 3'd1;
          end else begin
            dwell_cnt_d = dwell_inc[7:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      state_q       <= StIdle;
      // Reset to the inactive level so vsync held active at release is a boundary.
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
      mode_q        <= 3'd0;
      lat_mode_q    <= 3'd0;
      lat_auto_q    <= 1'b0;
      lat_dwell_q   <= 8'd0;
      dwell_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= vid_pVSync;
      frame_start_q <= fb;
      mode_q        <= mode_d;
      lat_mode_q    <= lat_mode_d;
      lat_auto_q    <= lat_auto_d;
      lat_dwell_q   <= lat_dwell_d;
      dwell_cnt_q   <= dwell_cnt_d;
    end
  end

`ifdef COLOURISE_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge PixelClk or posedge aRst) begin
    if (aRst) begin
      frame_cnt_q <= 16'd0;
    end else if (fb) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_colourise_ctrl.sv
// tb_colourise_ctrl -- directed self-checking bench for colourise_ctrl
// (default parameters: VSYNC_POL=1, MODE_MAX=1).
module tb_colourise_ctrl;

  logic        PixelClk;
  logic        aRst;
  logic        vid_pVSync;
  logic [2:0]  mode_out;
  logic        frame_start;
  logic        pending;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;

  colourise_ctrl_if cfg_if ();

  colourise_ctrl u_dut (
    .PixelClk    (PixelClk),
    .aRst        (aRst),
    .vid_pVSync  (vid_pVSync),
    .cfg         (cfg_if),
    .mode_out    (mode_out),
    .frame_start (frame_start),
    .pending     (pending),
    .frame_cnt   (frame_cnt)
  );

  initial begin
    PixelClk = 1'b0;
    forever #5 PixelClk = ~PixelClk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one frame boundary; returns at the negedge after the boundary edge.
  task automatic pulse_fb();
    vid_pVSync = 1'b1;
    @(negedge PixelClk);
    vid_pVSync = 1'b0;
    exp_frames++;
  endtask

  // Boundary, check resulting mode and frame_start, then one low cycle.
  task automatic frame_step(input string tag, input logic [2:0] exp_mode);
    pulse_fb();
    check_eq({tag, "_mode"}, 32'(mode_out), 32'(exp_mode));
    check_eq({tag, "_fs"}, 32'(frame_start), 32'd1);
    @(negedge PixelClk);
  endtask

  task automatic send_cfg(input logic [2:0] m, input logic a, input logic [7:0] d);
    check_eq("ready_before_req", 32'(cfg_if.cfg_ready), 32'd1);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mode  = m;
    cfg_if.cfg_auto  = a;
    cfg_if.cfg_dwell = d;
    @(negedge PixelClk);
    cfg_if.cfg_valid = 1'b0;
    check_eq("pending_after_req", 32'(pending), 32'd1);
    check_eq("ready_after_req", 32'(cfg_if.cfg_ready), 32'd0);
  endtask

  logic [2:0] seq_035 [6];
  logic [2:0] seq_036 [4];

  initial begin
    seq_035 = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0};
    seq_036 = '{3'd0, 3'd1, 3'd0, 3'd1};

    aRst             = 1'b1;
    vid_pVSync       = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_mode  = 3'd0;
    cfg_if.cfg_auto  = 1'b0;
    cfg_if.cfg_dwell = 8'd0;
    repeat (2) @(negedge PixelClk);
    check_eq("rst_mode", 32'(mode_out), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_fs", 32'(frame_start), 32'd0);
    check_eq("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check_eq("rst_fcnt", 32'(frame_cnt), 32'd0);
    aRst = 1'b0;
    @(negedge PixelClk);

    // Manual request applied on the next boundary.
    send_cfg(3'd1, 1'b0, 8'd0);
    repeat (3) @(negedge PixelClk);
    check_eq("wait_pending", 32'(pending), 32'd1);
    check_eq("wait_mode", 32'(mode_out), 32'd0);
    pulse_fb();
    check_eq("apply_mode", 32'(mode_out), 32'd1);
    check_eq("apply_fs", 32'(frame_start), 32'd1);
    check_eq("apply_pending", 32'(pending), 32'd0);
    check_eq("apply_ready", 32'(cfg_if.cfg_ready), 32'd1);
    @(negedge PixelClk);
    check_eq("fs_one_cycle", 32'(frame_start), 32'd0);

    // Accept on the same edge as a boundary: not applied until the next one.
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_mode  = 3'd0;
    cfg_if.cfg_auto  = 1'b0;
    cfg_if.cfg_dwell = 8'd0;
    vid_pVSync       = 1'b1;
    @(negedge PixelClk);
    cfg_if.cfg_valid = 1'b0;
    vid_pVSync       = 1'b0;
    exp_frames++;
    check_eq("same_fb_mode", 32'(mode_out), 32'd1);
    check_eq("same_fb_pending", 32'(pending), 32'd1);
    check_eq("same_fb_fs", 32'(frame_start), 32'd1);
    @(negedge PixelClk);
    frame_step("same_fb_next", 3'd0);

    // Out-of-range mode passes through unchanged in manual mode.
    send_cfg(3'd5, 1'b0, 8'd0);
    frame_step("manual_over", 3'd5);
    frame_step("idle_hold", 3'd5);

    // Auto, dwell 2, starting at mode 0.
    send_cfg(3'd0, 1'b1, 8'd2);
    for (int i = 0; i < 6; i++) begin
      frame_step($sformatf("auto_d2_%0d", i), seq_035[i]);
    end
    check_eq("auto_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check_eq("auto_pending", 32'(pending), 32'd0);

    // Request while auto-cycling freezes cycling until applied.
    send_cfg(3'd1, 1'b0, 8'd0);
    check_eq("freeze_mode", 32'(mode_out), 32'd0);
    frame_step("freeze_apply", 3'd1);
    frame_step("after_auto_idle", 3'd1);

    // Dwell 0 behaves as 1: toggles every frame.
    send_cfg(3'd0, 1'b1, 8'd0);
    for (int i = 0; i < 4; i++) begin
      frame_step($sformatf("auto_d0_%0d", i), seq_036[i]);
    end

    // Auto start mode is clamped to MODE_MAX.
    send_cfg(3'd6, 1'b1, 8'd1);
    frame_step("auto_clamp", 3'd1);
    frame_step("auto_clamp_wrap", 3'd0);
    frame_step("auto_clamp_again", 3'd1);

    // Reset while a request is pending discards it.
    send_cfg(3'd0, 1'b1, 8'd3);
    aRst = 1'b1;
    #1;
    check_eq("rst_mid_mode", 32'(mode_out), 32'd0);
    check_eq("rst_mid_pending", 32'(pending), 32'd0);
    exp_frames = 0;
    vid_pVSync = 1'b1;
    @(negedge PixelClk);
    aRst = 1'b0;
    @(negedge PixelClk);
    vid_pVSync = 1'b0;
    exp_frames++;
    check_eq("rel_vsync_fs", 32'(frame_start), 32'd1);
    check_eq("rel_vsync_mode", 32'(mode_out), 32'd0);
    @(negedge PixelClk);
    frame_step("post_rst_0", 3'd0);
    frame_step("post_rst_1", 3'd0);
    check_eq("post_rst_pending", 32'(pending), 32'd0);

`ifdef COLOURISE_CTRL_FRAME_CNT_EN
    check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
`else
    check_eq("frame_cnt", 32'(frame_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
